// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: FSM states, access
// sizes, transaction owner and the latched downstream command.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        OWNER_DATA = 1'b0,
        OWNER_INST = 1'b1
    } owner_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data has priority unless fetch has been
// passed over MAX_DATA_STREAK times in a row.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_W        = $clog2(MAX_DATA_STREAK + 1)
) (
    input  logic                inst_req,
    input  logic                data_req,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_inst,
    output logic                grant_data
);

    always_comb begin
        grant_inst = inst_req && (!data_req || (streak == STREAK_W'(MAX_DATA_STREAK)));
        grant_data = data_req && !grant_inst;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between instruction fetch and data access, one
// transaction at a time, steering each response back to the owning requester.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    state_t              state_q,  state_d;
    owner_t              owner_q,  owner_d;
    mem_cmd_t            cmd_q,    cmd_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic arb_en;
    logic grant_inst;
    logic grant_data;

    // Arbitration only happens in IDLE and is suppressed while reset is held,
    // so no addr_ok can pulse for a request that will never be latched.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    mem_arb_pick #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .STREAK_W        (STREAK_W)
    ) u_pick (
        .inst_req   (inst_req && arb_en),
        .data_req   (data_req && arb_en),
        .streak     (streak_q),
        .grant_inst (grant_inst),
        .grant_data (grant_data)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        streak_d     = streak_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_inst) begin
                    inst_addr_ok = 1'b1;
                    owner_d      = OWNER_INST;
                    cmd_d        = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'b0000,
                                     addr: inst_addr, wdata: 32'h0};
                    streak_d     = '0;
                    state_d      = ST_ADDR;
                end else if (grant_data) begin
                    data_addr_ok = 1'b1;
                    owner_d      = OWNER_DATA;
                    cmd_d        = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                                     addr: data_addr, wdata: data_wdata};
                    // Count only grants that made a waiting fetch lose.
                    if (!inst_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(MAX_DATA_STREAK)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_data_ok) begin
                    inst_data_ok = (owner_q == OWNER_INST);
                    data_data_ok = (owner_q == OWNER_DATA);
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_DATA;
            cmd_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cmd_q    <= cmd_d;
            streak_q <= streak_d;
        end
    end

    assign mem_wr     = cmd_q.wr;
    assign mem_size   = cmd_q.size;
    assign mem_wstrb  = cmd_q.wstrb;
    assign mem_addr   = cmd_q.addr;
    assign mem_wdata  = cmd_q.wdata;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule
